// File: rtl/lbp_stream.sv
// Streaming 3x3 local-binary-pattern engine over a row-major gray image.
// A sliding window fetches only the new right column (3 pixels) per result.
module lbp_stream #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 14,
  parameter int CMP_STRICT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [DATA_W-1:0] gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LOAD, S_CALC, S_WRITE, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [2:0]        rd_idx_q, rd_idx_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        pend_row_q, pend_row_d, pend_col_q, pend_col_d;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  logic [1:0]        tgt_row, tgt_col;
  logic [2:0]        rd_last;
  logic [ADDR_W-1:0] rd_row, rd_col, rd_addr;
  logic [7:0]        code;

  function automatic logic nb_bit(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] c);
    if (CMP_STRICT != 0) return n > c;
    else                 return n >= c;
  endfunction

  // FILL walks columns 0 and 1 top to bottom; LOAD walks column 2.
  always_comb begin
    tgt_row = 2'd0;
    tgt_col = 2'd2;
    rd_last = 3'd2;
    if (state_q == S_FILL) begin
      rd_last = 3'd5;
      case (rd_idx_q)
        3'd0:    begin tgt_row = 2'd0; tgt_col = 2'd0; end
        3'd1:    begin tgt_row = 2'd1; tgt_col = 2'd0; end
        3'd2:    begin tgt_row = 2'd2; tgt_col = 2'd0; end
        3'd3:    begin tgt_row = 2'd0; tgt_col = 2'd1; end
        3'd4:    begin tgt_row = 2'd1; tgt_col = 2'd1; end
        default: begin tgt_row = 2'd2; tgt_col = 2'd1; end
      endcase
    end else begin
      tgt_row = rd_idx_q[1:0];
    end
    rd_row  = row_q - ADDR_W'(1) + ADDR_W'(tgt_row);
    rd_col  = (state_q == S_FILL) ? ADDR_W'(tgt_col) : col_q + ADDR_W'(1);
    rd_addr = rd_row * W_A + rd_col;
  end

  assign code = {nb_bit(win_q[2][2], win_q[1][1]), nb_bit(win_q[2][1], win_q[1][1]),
                 nb_bit(win_q[2][0], win_q[1][1]), nb_bit(win_q[1][2], win_q[1][1]),
                 nb_bit(win_q[1][0], win_q[1][1]), nb_bit(win_q[0][2], win_q[1][1]),
                 nb_bit(win_q[0][1], win_q[1][1]), nb_bit(win_q[0][0], win_q[1][1])};

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rd_idx_d   = rd_idx_q;
    rd_pend_d  = 1'b0;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    win_d      = win_q;
    gray_req   = 1'b0;
    gray_addr  = '0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;

    // A read issued last cycle lands regardless of the current stall state.
    if (rd_pend_q) win_d[pend_row_q][pend_col_q] = gray_data;

    unique case (state_q)
      S_IDLE: begin
        if (gray_ready) begin
          state_d  = S_FILL;
          row_d    = ADDR_W'(1);
          col_d    = ADDR_W'(1);
          rd_idx_d = '0;
        end
      end
      S_FILL, S_LOAD: begin
        if (gray_ready) begin
          gray_req   = 1'b1;
          gray_addr  = rd_addr;
          rd_pend_d  = 1'b1;
          pend_row_d = tgt_row;
          pend_col_d = tgt_col;
          if (rd_idx_q == rd_last) begin
            rd_idx_d = '0;
            state_d  = (state_q == S_FILL) ? S_LOAD : S_CALC;
          end else begin
            rd_idx_d = rd_idx_q + 3'd1;
          end
        end
      end
      S_CALC: state_d = S_WRITE;
      S_WRITE: begin
        lbp_valid = 1'b1;
        lbp_addr  = row_q * W_A + col_q;
        lbp_data  = code;
        for (int i = 0; i < 3; i++) begin
          win_d[i][0] = win_q[i][1];
          win_d[i][1] = win_q[i][2];
        end
        if (col_q != LAST_COL) begin
          col_d   = col_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else if (row_q != LAST_ROW) begin
          row_d   = row_q + ADDR_W'(1);
          col_d   = ADDR_W'(1);
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  finish = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      rd_idx_q   <= '0;
      rd_pend_q  <= 1'b0;
      pend_row_q <= '0;
      pend_col_q <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_idx_q   <= rd_idx_d;
      rd_pend_q  <= rd_pend_d;
      pend_row_q <= pend_row_d;
      pend_col_q <= pend_col_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: doc/lbp_stream.md
Name: lbp_stream

Overview:
- Parametrised successor of the gray-to-LBP engine.
- Reads a row-major IMG_W x IMG_H gray image from external memory and computes the 8-bit local binary pattern for every interior pixel.
- Writes each result to the LBP memory, then raises finish.
- Uses a sliding 3x3 window: fetches only the 3 pixels of the new right column per output pixel, not 9, and offers selectable compare mode.

Parameters:
- IMG_W, 128, image width in pixels (>=3).
- IMG_H, 128, image height in pixels (>=3).
- DATA_W, 8, gray pixel width in bits.
- ADDR_W, 14, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- CMP_STRICT, 0, neighbour bit = 1 when neighbour >= center (0) or neighbour > center (1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- gray_ready  in  1  gray memory available; reads are issued only while high.
- gray_addr  out  ADDR_W  gray read address.
- gray_req  out  1  read request; high on every cycle a read address is issued.
- gray_data  in  DATA_W  read data; valid the cycle after the issuing cycle.
- lbp_addr  out  ADDR_W  result address, r*IMG_W+c.
- lbp_valid  out  1  one-cycle write strobe for lbp_addr/lbp_data.
- lbp_data  out  8  LBP code.
- finish  out  1  high once all interior results are written.

Behaviour:
- Reset (sampled at clk edge) forces state IDLE and every output to 0. Row/column counters and window registers clear to 0. Reset mid-frame aborts the frame; processing restarts at pixel (1,1) after reset drops.
- Window registers: w[row 0..2][col 0..2] of DATA_W bits. Center is w[1][1].
- Code bit order:
  - bit0 = TL, bit1 = T, bit2 = TR, bit3 = L
  - bit4 = R, bit5 = BL, bit6 = B, bit7 = BR
- Each bit is the unsigned compare against the center per CMP_STRICT.
- States:
  - IDLE: leave when gray_ready=1 -> FILL; row r=1, column c=1.
  - FILL: issue 6 reads, in order (r-1,0),(r,0),(r+1,0),(r-1,1),(r,1),(r+1,1). Loads window columns 0 and 1. -> LOAD.
  - LOAD: issue 3 reads (r-1,c+1),(r,c+1),(r+1,c+1) into window column 2. -> CALC after the last issue.
  - CALC: capture the last returned datum. -> WRITE.
  - WRITE: drive lbp_valid=1, lbp_addr=r*IMG_W+c, lbp_data=code for one cycle. Shift window left (col0<=col1, col1<=col2). Then:
    - c<IMG_W-2: c+1, go to LOAD.
    - c=IMG_W-2 and r<IMG_H-2: r+1, c=1, go to FILL.
    - last pixel (IMG_H-2, IMG_W-2): go to DONE.
  - DONE: finish=1, gray_req=0, lbp_valid=0; hold until reset.
- Read stall: while gray_ready=0 no read is issued, gray_req=0, and the FSM holds position. A read already issued is still captured next cycle regardless of gray_ready.
- Addresses are computed as row*IMG_W+col in ADDR_W bits, never negative. Border pixels are read but never written.
- Throughput with gray_ready held high:
  - 5 cycles per interior pixel.
  - Plus 6 cycles at each row start.
  - First lbp_valid no later than 14 cycles after leaving IDLE.
- lbp_valid is exactly one cycle per result. There are exactly (IMG_W-2)*(IMG_H-2) results, in raster order, with no duplicates.
- finish rises the cycle after the last lbp_valid and never deasserts before reset.

Test Plan:
- IMG_W=IMG_H=4, pixel=column index (0,1,2,3 per row), CMP_STRICT=0 -> addr 5 and 9 get 0xD6.
- Same image, CMP_STRICT=1 -> addr 5 and 9 get 0x94.
- IMG_W=IMG_H=4, all pixels 0x55 -> 4 writes (addr 5,6,9,10) of 0xFF with CMP_STRICT=0, 0x00 with CMP_STRICT=1. finish=1 the cycle after the 4th write.
- Default 128x128 with random image vs golden model -> 15876 writes, all matching, addresses 129..16254 skipping borders. Read count = 126*(6+3*126).
- Toggle gray_ready randomly (50% low) during the 128x128 run -> identical results, gray_req never high while gray_ready low.
- Assert reset for 1 cycle mid-row (after 3rd write) -> all outputs 0 next cycle. Restarted frame output equals the full golden sequence from addr 129.
